// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared block-type encoding and piece-queue state encoding,
//               used by the block counter and the piece queue.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  localparam int BLOCK_W = 3;

  // Block shapes; code 7 is never a real piece.
  typedef enum logic [BLOCK_W-1:0] {
    BLOCK_L       = 3'd0,
    BLOCK_T       = 3'd1,
    BLOCK_I       = 3'd2,
    BLOCK_DOT     = 3'd3,
    BLOCK_SQUARE  = 3'd4,
    BLOCK_CROSS   = 3'd5,
    BLOCK_STEPS   = 3'd6,
    BLOCK_INVALID = 3'd7
  } block_t;

  // Queue controller: refilling (no pops) or running (pops allowed).
  typedef enum logic [0:0] {
    Q_FILL = 1'b0,
    Q_RUN  = 1'b1
  } queue_state_t;

  // True for the one code that does not name a block.
  function automatic logic is_invalid_block(input logic [BLOCK_W-1:0] b);
    return b == BLOCK_INVALID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piece_fifo.sv
`default_nettype none
// ============================================================================
// Module      : piece_fifo
// Description : DEPTH-entry circular store of block types with push, pop and
//               clear, exposing the head entry and the entry behind it.
//               Slots that hold no piece read as BLOCK_SQUARE.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [BLOCK_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [BLOCK_W-1:0] head_o,
  output logic [BLOCK_W-1:0] next_o,
  output logic [CW-1:0]      count_o
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  logic [BLOCK_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               w_push;
  logic               w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // Guard against underflow and against pushing into a full store without a pop.
  always_comb begin
    w_pop  = pop_i && (r_count != '0);
    w_push = push_i && ((r_count != c_FULL) || w_pop);
  end

  // Storage, pointers and occupancy; clear empties the queue but keeps stale data.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= BLOCK_SQUARE;
      end
    end else if (clear_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= inc_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= inc_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read ports mask empty slots so stale data never reaches the display.
  always_comb begin
    head_o  = (r_count != '0)  ? r_mem[r_rd_ptr]          : BLOCK_SQUARE;
    next_o  = (r_count > c_ONE) ? r_mem[inc_ptr(r_rd_ptr)] : BLOCK_SQUARE;
    count_o = r_count;
  end

endmodule
`default_nettype wire

// File: rtl/piece_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : piece_queue_ctrl
// Description : Filters the free-running block candidate (drops code 7 and
//               limits immediate repeats), feeds the piece FIFO and hands
//               pieces to the game FSM once the queue has been filled.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_queue_ctrl
  import tetris_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MAX_REJECT = 2
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [BLOCK_W-1:0]         rand_i,
  input  logic                       flush_i,
  input  logic                       spawn_ready_i,
  output logic                       spawn_valid_o,
  output logic [BLOCK_W-1:0]         spawn_type_o,
  output logic [BLOCK_W-1:0]         preview_type_o,
  output logic [$clog2(DEPTH+1)-1:0] queue_count_o
);

  localparam int            CW          = $clog2(DEPTH + 1);
  localparam int            RW          = (MAX_REJECT > 0) ? $clog2(MAX_REJECT + 1) : 1;
  localparam logic [CW-1:0] c_FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] c_ALMOST    = CW'(DEPTH - 1);
  localparam logic [RW-1:0] c_MAX_REJ   = RW'(MAX_REJECT);

  queue_state_t       r_state;
  queue_state_t       w_state_nxt;
  logic [BLOCK_W-1:0] r_last_pushed;
  logic [RW-1:0]      r_reject_cnt;
  logic [RW-1:0]      w_reject_nxt;
  logic [CW-1:0]      w_count;
  logic               w_invalid;
  logic               w_repeat;
  logic               w_accept;
  logic               w_eval;
  logic               w_push;
  logic               w_pop;

  // State, repeat-limit counter and last pushed type.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= Q_FILL;
      r_reject_cnt  <= '0;
      r_last_pushed <= BLOCK_SQUARE;
    end else begin
      r_state      <= w_state_nxt;
      r_reject_cnt <= w_reject_nxt;
      if (w_push) begin
        r_last_pushed <= rand_i;
      end
    end
  end

  // Next state, candidate filter and handshake; flush overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    w_reject_nxt  = r_reject_cnt;
    w_pop         = 1'b0;
    w_eval        = 1'b0;
    w_push        = 1'b0;
    spawn_valid_o = (r_state == Q_RUN) && (w_count != '0);
    w_invalid     = is_invalid_block(rand_i);
    w_repeat      = (rand_i == r_last_pushed);
    w_accept      = !w_invalid && (!w_repeat || (r_reject_cnt == c_MAX_REJ));

    if (flush_i) begin
      w_state_nxt  = Q_FILL;
      w_reject_nxt = '0;
    end else begin
      w_pop  = spawn_valid_o && spawn_ready_i;
      // A full queue with no pop leaves the candidate unexamined.
      w_eval = (w_count != c_FULL) || w_pop;
      w_push = w_eval && w_accept;
      // Code 7 never touches the repeat counter; only repeats below the limit bump it.
      if (w_eval && !w_invalid) begin
        w_reject_nxt = w_accept ? '0 : r_reject_cnt + 1'b1;
      end
      if ((r_state == Q_FILL) && w_push && (w_count == c_ALMOST)) begin
        w_state_nxt = Q_RUN;
      end
    end
  end

  piece_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (w_push),
    .push_data_i (rand_i),
    .pop_i       (w_pop),
    .head_o      (spawn_type_o),
    .next_o      (preview_type_o),
    .count_o     (w_count)
  );

  assign queue_count_o = w_count;

endmodule
`default_nettype wire
